dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with starvation-bounded fixed priority.
// Port A (CPU MEM stage) normally wins conflicts. Port B (loader/debug)
// gets one priority cycle after waiting STARVE_MAX consecutive cycles.
// Grants are combinational in the request cycle. Read data is registered
// per port on the edge that closes the grant cycle.
module dmem_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 7
) (
    input  logic              clk,
    input  logic              rst,
    // port A
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_stall,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    // port B
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    // memory side
    output logic              mem_ena,
    output logic              mem_wena,
    output logic              mem_rena,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // debug
    output logic [3:0]        starve_cnt
);

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] starve_reg;
    logic [3:0] starve_next;

    // Per-port read tracking, index 0 = A, 1 = B.
    logic              rd_gnt     [2];
    logic              rvalid_reg [2];
    logic [DATA_W-1:0] rdata_reg  [2];

    // State register: priority FSM and port B wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= PRI_A;
            starve_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
        end
    end

    // Next-state: count B's lost cycles, hand B priority once the count
    // reaches the limit, and return to A after B is served or gives up.
    always_comb begin
        starve_next = 4'd0;
        if (b_req && !b_gnt) begin
            starve_next = (starve_reg >= STARVE_LIM) ? STARVE_LIM : starve_reg + 4'd1;
        end

        state_next = state_reg;
        case (state_reg)
            PRI_A: begin
                if (b_req && !b_gnt && (starve_next == STARVE_LIM)) begin
                    state_next = PRI_B;
                end
            end
            PRI_B: begin
                if (b_gnt || !b_req) begin
                    state_next = PRI_A;
                end
            end
            default: state_next = PRI_A;
        endcase
    end

    // Outputs: pick the winner for this cycle and route it to memory.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (state_reg == PRI_B) begin
                b_gnt = b_req;
                a_gnt = a_req && !b_req;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req && !a_req;
            end
        end

        a_stall   = a_req && !a_gnt;
        mem_ena   = a_gnt || b_gnt;
        mem_wena  = 1'b0;
        mem_rena  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (a_gnt) begin
            mem_wena  = a_we;
            mem_rena  = !a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_wena  = b_we;
            mem_rena  = !b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    assign rd_gnt[0] = a_gnt && !a_we;
    assign rd_gnt[1] = b_gnt && !b_we;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // Capture read data at the end of a read grant; rvalid pulses
            // for one cycle, rdata holds until the next read to this port.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_reg[gi] <= 1'b0;
                    rdata_reg[gi]  <= '0;
                end else begin
                    rvalid_reg[gi] <= rd_gnt[gi];
                    if (rd_gnt[gi]) begin
                        rdata_reg[gi] <= mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign a_rvalid   = rvalid_reg[0];
    assign a_rdata    = rdata_reg[0];
    assign b_rvalid   = rvalid_reg[1];
    assign b_rdata    = rdata_reg[1];
    assign starve_cnt = starve_reg;

endmodule
